// File: rtl/priv_trap_sequencer.sv
// Trap/xRET sequencer: prioritise, drain, redirect, commit.
// Optional VECTORED_TRAP_EN: vectored interrupt targets.
module priv_trap_sequencer #(
  parameter logic [31:0] RESET_PC_BASE = 32'h0000_0200,
  parameter int unsigned DRAIN_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [15:0] exc_vec,
  input  logic [31:0] epc,
  input  logic [31:0] badaddr,
  input  logic        timer_int,
  input  logic        soft_int,
  input  logic        ext_int,
  input  logic        mie_global,
  input  logic        mret,
  input  logic        pipe_clear,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc_r,
  output logic        insert_pc,
  output logic [31:0] priv_pc,
  output logic        intr,
  output logic        trap_commit,
  output logic        ret_commit,
  output logic [4:0]  cause_o,
  output logic        cause_intr_o,
  output logic [31:0] epc_o,
  output logic [31:0] tval_o
);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    COMMIT
  } state_t;

  localparam logic [15:0] EXC_MASK  = 16'hBBFF;
  localparam logic [15:0] TVAL_MASK = 16'hB0F3;
  localparam bit          TO_EN     = (DRAIN_TIMEOUT != 0);
  localparam logic [4:0]  TO_LAST   = 5'(DRAIN_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic        is_ret_q;
  logic [4:0]  cause_q;
  logic        cause_intr_q;
  logic [31:0] epc_q;
  logic [31:0] tval_q;
  logic [31:0] pc_q;

  logic [15:0] exc_v;
  logic        exc_any;
  logic        int_any;
  logic        detect;
  logic [4:0]  exc_code;
  logic [4:0]  int_code;
  logic [31:0] exc_tval;
  logic        to_hit;
  logic [31:0] target;

  assign exc_v   = exc_vec & EXC_MASK;
  assign exc_any = |exc_v;
  assign int_any = mie_global &
                   (ext_int | soft_int | timer_int);
  assign detect  = exc_any | mret | int_any;
  assign to_hit  = TO_EN && (cnt_q == TO_LAST);

  // Fixed exception priority, highest first.
  always_comb begin
    exc_code = 5'd0;
    if      (exc_v[3])  exc_code = 5'd3;
    else if (exc_v[12]) exc_code = 5'd12;
    else if (exc_v[1])  exc_code = 5'd1;
    else if (exc_v[2])  exc_code = 5'd2;
    else if (exc_v[0])  exc_code = 5'd0;
    else if (exc_v[8])  exc_code = 5'd8;
    else if (exc_v[9])  exc_code = 5'd9;
    else if (exc_v[11]) exc_code = 5'd11;
    else if (exc_v[6])  exc_code = 5'd6;
    else if (exc_v[4])  exc_code = 5'd4;
    else if (exc_v[15]) exc_code = 5'd15;
    else if (exc_v[13]) exc_code = 5'd13;
    else if (exc_v[7])  exc_code = 5'd7;
    else if (exc_v[5])  exc_code = 5'd5;
  end

  assign int_code = ext_int  ? 5'd11 :
                    soft_int ? 5'd3  : 5'd7;

  assign exc_tval = TVAL_MASK[exc_code[3:0]] ?
                    badaddr : 32'd0;

  // Redirect target for the commit cycle.
  always_comb begin
    target = {mtvec[31:2], 2'b00};
    if (is_ret_q)
      target = {mepc_r[31:2], 2'b00};
`ifdef VECTORED_TRAP_EN
    else if (cause_intr_q && mtvec[1:0] == 2'b01)
      target = {mtvec[31:2], 2'b00} +
               {25'd0, cause_q, 2'b00};
`endif
  end

`ifndef VECTORED_TRAP_EN
  logic unused_mode;
  assign unused_mode = ^mtvec[1:0];
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (detect) state_d = DRAIN;
      DRAIN:   if (pipe_clear || to_hit)
                 state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and drain counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != DRAIN)
        cnt_q <= '0;
      else if (cnt_q != 5'h1f)
        cnt_q <= cnt_q + 5'd1;
    end
  end

  // Latch the event at detect; hold through drain.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      is_ret_q     <= 1'b0;
      cause_q      <= '0;
      cause_intr_q <= 1'b0;
      epc_q        <= '0;
      tval_q       <= '0;
    end else if (state_q == IDLE && detect) begin
      if (exc_any) begin
        is_ret_q     <= 1'b0;
        cause_q      <= exc_code;
        cause_intr_q <= 1'b0;
        epc_q        <= epc;
        tval_q       <= exc_tval;
      end else if (mret) begin
        is_ret_q     <= 1'b1;
      end else begin
        is_ret_q     <= 1'b0;
        cause_q      <= int_code;
        cause_intr_q <= 1'b1;
        epc_q        <= epc;
        tval_q       <= '0;
      end
    end
  end

  // Last redirect target, held outside commit.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      pc_q <= RESET_PC_BASE;
    else if (state_q == COMMIT)
      pc_q <= target;
  end

  assign insert_pc    = (state_q == COMMIT);
  assign intr         = (state_q != IDLE);
  assign trap_commit  = insert_pc & ~is_ret_q;
  assign ret_commit   = insert_pc & is_ret_q;
  assign priv_pc      = insert_pc ? target : pc_q;
  assign cause_o      = cause_q;
  assign cause_intr_o = cause_intr_q;
  assign epc_o        = epc_q;
  assign tval_o       = tval_q;

endmodule

// File: tb/tb_priv_trap_sequencer.sv
// Bench for priv_trap_sequencer: directed + random
// events against a behavioural trap model.
module tb_priv_trap_sequencer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [15:0] exc_vec;
  logic [31:0] epc, badaddr, mtvec, mepc_r;
  logic        timer_int, soft_int, ext_int;
  logic        mie_global, mret, pipe_clear;
  logic        insert_pc, intr;
  logic        trap_commit, ret_commit;
  logic [31:0] priv_pc, epc_o, tval_o;
  logic [4:0]  cause_o;
  logic        cause_intr_o;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] last_pc;

  localparam int TO = 16;

  always #5 CLK = ~CLK;

  priv_trap_sequencer dut (
    .CLK(CLK), .nRST(nRST),
    .exc_vec(exc_vec), .epc(epc),
    .badaddr(badaddr), .timer_int(timer_int),
    .soft_int(soft_int), .ext_int(ext_int),
    .mie_global(mie_global), .mret(mret),
    .pipe_clear(pipe_clear), .mtvec(mtvec),
    .mepc_r(mepc_r), .insert_pc(insert_pc),
    .priv_pc(priv_pc), .intr(intr),
    .trap_commit(trap_commit),
    .ret_commit(ret_commit),
    .cause_o(cause_o),
    .cause_intr_o(cause_intr_o),
    .epc_o(epc_o), .tval_o(tval_o)
  );

  // Reference: what trap the spec's rules pick.
  function automatic void model(
    input  logic [15:0] ex,
    input  logic ti, si, ei, mie, mr,
    input  logic [31:0] ba, tv, mp,
    output bit is_ret, output bit is_int,
    output logic [4:0] c,
    output logic [31:0] tval,
    output logic [31:0] pcx
  );
    int order[14] = '{3, 12, 1, 2, 0, 8, 9,
                      11, 6, 4, 15, 13, 7, 5};
    int tvc[9] = '{0, 1, 4, 5, 6, 7, 12, 13, 15};
    bit found = 0;
    is_ret = 0; is_int = 0; c = 0; tval = 0;
    foreach (order[i])
      if (!found && ex[order[i]]) begin
        found = 1;
        c = 5'(order[i]);
      end
    if (found) begin
      foreach (tvc[i])
        if (tvc[i] == int'(c)) tval = ba;
    end else if (mr) begin
      is_ret = 1;
    end else begin
      is_int = 1;
      c = ei ? 5'd11 : si ? 5'd3 : 5'd7;
    end
    if (is_ret) pcx = mp & ~32'd3;
    else begin
      pcx = tv & ~32'd3;
`ifdef VECTORED_TRAP_EN
      if (is_int && tv[1:0] == 2'b01)
        pcx = pcx + 32'(c) * 4;
`endif
    end
  endfunction

  task automatic clr_events();
    exc_vec = 0; timer_int = 0; soft_int = 0;
    ext_int = 0; mret = 0;
  endtask

  // Present one event at cycle 0, drive pipe_clear
  // from DRAIN cycle clear_at, check the commit.
  task automatic run_event(
    input string tag,
    input logic [15:0] ex,
    input logic ti, si, ei, mie, mr,
    input logic [31:0] pc, ba, tv, mp,
    input int clear_at, input bit hold
  );
    bit is_ret, is_int;
    logic [4:0] ec;
    logic [31:0] etv, epx;
    int exp_cyc, got_cyc, ca;
    model(ex, ti, si, ei, mie, mr, ba, tv, mp,
          is_ret, is_int, ec, etv, epx);
    ca = (clear_at < 1) ? 1 : clear_at;
    exp_cyc = ((ca < TO) ? ca : TO) + 1;
    @(negedge CLK);
    n_chk++;
    if (intr !== 0 || insert_pc !== 0 ||
        trap_commit !== 0 || ret_commit !== 0 ||
        priv_pc !== last_pc) begin
      n_fail++;
      $display("FAIL %s idle: intr=%b ins=%b tc=%b rc=%b pc=%h want 0000 pc=%h",
               tag, intr, insert_pc, trap_commit,
               ret_commit, priv_pc, last_pc);
    end
    exc_vec = ex; timer_int = ti; soft_int = si;
    ext_int = ei; mie_global = mie; mret = mr;
    epc = pc; badaddr = ba; mtvec = tv;
    mepc_r = mp;
    pipe_clear = (clear_at <= 0);
    got_cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge CLK);
      if (!hold) begin
        clr_events();
        epc = $urandom; badaddr = $urandom;
      end
      if (c == 1) begin
        n_chk++;
        if (intr !== 1) begin
          n_fail++;
          $display("FAIL %s intr: got %b want 1",
                   tag, intr);
        end
      end
      if (insert_pc === 1'b1) begin
        got_cyc = c;
        break;
      end
      pipe_clear = (c >= clear_at);
    end
    n_chk++;
    if (got_cyc != exp_cyc) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d",
               tag, got_cyc, exp_cyc);
    end
    if (got_cyc > 0) begin
      n_chk++;
      if (trap_commit !== !is_ret ||
          ret_commit !== is_ret ||
          priv_pc !== epx) begin
        n_fail++;
        $display("FAIL %s commit: tc=%b rc=%b pc=%h want %b %b %h",
                 tag, trap_commit, ret_commit, priv_pc,
                 !is_ret, is_ret, epx);
      end
      if (!is_ret) begin
        n_chk++;
        if (cause_o !== ec ||
            cause_intr_o !== is_int ||
            epc_o !== pc || tval_o !== etv) begin
          n_fail++;
          $display("FAIL %s csr: c=%0d i=%b epc=%h tval=%h want %0d %b %h %h",
                   tag, cause_o, cause_intr_o, epc_o,
                   tval_o, ec, is_int, pc, etv);
        end
      end
    end
    last_pc = epx;
    pipe_clear = 0;
  endtask

  task automatic test_reset();
    clr_events();
    epc = 0; badaddr = 0; mtvec = 0; mepc_r = 0;
    mie_global = 0; pipe_clear = 0;
    nRST = 0;
    repeat (3) @(negedge CLK);
    n_chk++;
    if (insert_pc !== 0 || intr !== 0 ||
        trap_commit !== 0 || ret_commit !== 0) begin
      n_fail++;
      $display("FAIL reset_ctl: %b%b%b%b want 0000",
               insert_pc, intr, trap_commit, ret_commit);
    end
    n_chk++;
    if (cause_o !== 0 || cause_intr_o !== 0 ||
        epc_o !== 0 || tval_o !== 0) begin
      n_fail++;
      $display("FAIL reset_csr: c=%0d i=%b e=%h t=%h want zeros",
               cause_o, cause_intr_o, epc_o, tval_o);
    end
    n_chk++;
    if (priv_pc !== 32'h200) begin
      n_fail++;
      $display("FAIL reset_pc: got %h want 200",
               priv_pc);
    end
    nRST = 1;
    last_pc = 32'h200;
  endtask

  task automatic test_basic();
    run_event("basic", 16'h0004, 0, 0, 0, 0, 0,
              32'h100, 32'hdead, 32'h800, 0, 3, 0);
    run_event("minlat", 16'h0100, 0, 0, 0, 0, 0,
              32'h104, 32'h55, 32'h900, 0, 1, 0);
    run_event("sameclr", 16'h0001, 0, 0, 0, 0, 0,
              32'h108, 32'h66, 32'h904, 0, 0, 0);
  endtask

  task automatic test_priority();
    run_event("pri32", 16'h000C, 0, 0, 0, 0, 0,
              32'h200, 32'h1003, 32'h800, 0, 2, 0);
    run_event("tval4", 16'h0010, 0, 0, 0, 0, 0,
              32'h204, 32'h1003, 32'h800, 0, 2, 0);
    run_event("pri_ld", 16'hA880, 1, 0, 0, 1, 1,
              32'h208, 32'h77, 32'h800, 0, 2, 0);
    @(negedge CLK);
    exc_vec = 16'h4400;
    repeat (3) @(negedge CLK);
    n_chk++;
    if (intr !== 0) begin
      n_fail++;
      $display("FAIL unused_code: intr=%b want 0",
               intr);
    end
    clr_events();
  endtask

  task automatic test_interrupt();
    run_event("irq_vec", 0, 1, 0, 1, 1, 0,
              32'h300, 32'h9, 32'h801, 0, 2, 0);
    run_event("irq_sw", 0, 1, 1, 0, 1, 0,
              32'h304, 32'h9, 32'h801, 0, 4, 0);
    @(negedge CLK);
    mie_global = 0; timer_int = 1; ext_int = 1;
    repeat (3) @(negedge CLK);
    n_chk++;
    if (intr !== 0) begin
      n_fail++;
      $display("FAIL irq_masked: intr=%b want 0",
               intr);
    end
    clr_events();
  endtask

  task automatic test_mret();
    run_event("mret", 0, 1, 0, 0, 1, 1,
              32'h400, 0, 32'h800, 32'h1234, 2, 1);
    run_event("mret_tmr", 0, 1, 0, 0, 1, 0,
              32'h400, 0, 32'h800, 32'h1234, 2, 0);
  endtask

  task automatic test_timeout();
    run_event("timeout", 16'h0020, 0, 0, 0, 0, 0,
              32'h500, 32'h42, 32'hA00, 0, 100, 0);
  endtask

  task automatic test_reset_drain();
    @(negedge CLK);
    exc_vec = 16'h0001; mtvec = 32'hC00;
    epc = 32'h600; badaddr = 32'h44;
    @(negedge CLK);
    clr_events();
    @(negedge CLK);
    nRST = 0;
    #1;
    n_chk++;
    if (intr !== 0 || insert_pc !== 0 ||
        trap_commit !== 0 || priv_pc !== 32'h200 ||
        cause_o !== 0 || epc_o !== 0 ||
        tval_o !== 0 || cause_intr_o !== 0) begin
      n_fail++;
      $display("FAIL rst_drain: intr=%b ins=%b pc=%h epc=%h want 0 0 200 0",
               intr, insert_pc, priv_pc, epc_o);
    end
    @(negedge CLK);
    nRST = 1;
    pipe_clear = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      n_chk++;
      if (trap_commit !== 0 || insert_pc !== 0 ||
          intr !== 0) begin
        n_fail++;
        $display("FAIL rst_release: tc=%b ins=%b intr=%b want 000",
                 trap_commit, insert_pc, intr);
      end
    end
    pipe_clear = 0;
    last_pc = 32'h200;
  endtask

  task automatic test_random();
    logic [15:0] ex;
    logic ti, si, ei, mie, mr;
    for (int n = 0; n < 25; n++) begin
      ex  = ($urandom_range(0, 2) == 0) ?
            16'h0 : 16'($urandom);
      ti  = 1'($urandom); si = 1'($urandom);
      ei  = 1'($urandom); mie = 1'($urandom);
      mr  = ($urandom_range(0, 3) == 0);
      if ((ex & 16'hBBFF) == 0 && !mr &&
          !(mie && (ti || si || ei)))
        ex[0] = 1'b1;
      run_event("rand", ex, ti, si, ei, mie, mr,
                $urandom, $urandom, $urandom,
                $urandom, $urandom_range(0, 20), 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_interrupt();
    test_mret();
    test_timeout();
    test_reset_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
